mem_arb: RTL and testbench
==========================

# mem_arb

Two-port arbiter and sequencer for the single unified memory shared by instruction fetch and the MEM-stage data access. It accepts one request per port, grants one at a time, drives the memory's enable/address/data and waits for the memory's completion strobe. It then returns a one-cycle `done` with registered read data to the winning port. Stall outputs feed the pipeline's PC-stall/NOP logic the same way the hazard unit's outputs do.

## Interface
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 16: data width.
- `TIMEOUT`, default 15: maximum cycles spent waiting for `mem_done` before the access is aborted.

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous reset, active-low (0 = reset).
- `if_req`  in  1  fetch request.
- `if_addr`  in  ADDR_W  fetch address.
- `if_flush`  in  1  branch/jump redirect; cancels the current fetch.
- `if_rdata`  out  DATA_W  fetched instruction, valid when `if_done` = 1.
- `if_done`  out  1  one-cycle fetch completion.
- `if_stall`  out  1  fetch waiting: `if_req & ~if_done`.
- `dm_req`  in  1  data request.
- `dm_wr`  in  1  1 = write, 0 = read.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  write data.
- `dm_rdata`  out  DATA_W  read data, valid when `dm_done` = 1.
- `dm_done`  out  1  one-cycle data completion.
- `dm_stall`  out  1  data access waiting: `dm_req & ~dm_done`.
- `mem_en`  out  1  memory access active.
- `mem_wr`  out  1  memory write.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_done`.
- `mem_done`  in  1  memory completion strobe.
- `err`  out  1  pulses with `done` when an access timed out.

## Operation
- The FSM has four states: IDLE, BUSY_IF, BUSY_DM and RESP.
- **IDLE**
  - `dm_req` = 1 → BUSY_DM.
  - Else `if_req & ~if_flush` = 1 → BUSY_IF.
  - Both requesting: data wins (fixed priority; see Configuration).
- **Grant**
  - `wr`, `addr` and `wdata` are captured into registers at the IDLE→BUSY edge.
  - `mem_*` outputs are driven only from these registers, never from port inputs.
  - Requesters must hold `req` and operands stable until `done`.
- **BUSY_x**
  - `mem_en` = 1; the wait counter increments each cycle.
  - On `mem_done` = 1: capture `mem_rdata` into the owner's rdata register, then go to RESP.
  - If the counter reaches TIMEOUT first: go to RESP with an error flag set and rdata forced to 0.
- **RESP**
  - Assert the owner's `done` for exactly one cycle; assert `err` if flagged; `mem_en` = 0.
  - Next state is always IDLE. No grant occurs in RESP, so a stale request held during `done` is never re-granted.
- **Flush**
  - `if_flush` in BUSY_IF: the memory access runs to completion (it cannot be aborted).
  - A flush-pending bit is set, and in RESP `if_done` is suppressed and `if_rdata` is not updated.
  - `if_flush` in RESP for a fetch also suppresses `if_done`.
  - Flush has no effect on data accesses.
- **Writes**: `dm_rdata` is not updated; `dm_done` is still pulsed.
- **Spurious strobe**: `mem_done` in IDLE or RESP is ignored.

## Timing
- **Reset values**: state = IDLE; every output = 0; rdata registers = 0; wait counter = 0; flush-pending = 0; RR pointer = "last granted IF".
- **Reset mid-access**: all outputs drop to 0 immediately. No `done` is issued for the aborted access.
- **Latency**: with the memory asserting `mem_done` in the Nth BUSY cycle (N ≥ 1), `done` comes N+1 cycles after the grant cycle.
  - Minimum request-to-done latency is 3 cycles: IDLE, BUSY ×1, RESP.
  - Back-to-back throughput on one port is one access per N+2 cycles.
- **Timeout**: `err` and `done` assert in the cycle after TIMEOUT BUSY cycles. The wait counter is ceil(log2(TIMEOUT+1)) bits wide and saturates, never wraps.
- **`mem_done` in the same cycle the counter hits TIMEOUT**: this is a normal completion; `err` = 0.
- **Stall outputs**: `if_stall` and `dm_stall` are combinational from `req` and the registered `done`.

## Configuration
- **`MEM_ARB_RR_EN` defined**: when both ports request in IDLE, grant the port not granted last. The 1-bit pointer updates on every grant.
- **`MEM_ARB_RR_EN` undefined**: fixed data-over-fetch priority; the pointer is not implemented.

## Structure
- **Shared package**:
  - State enum `mem_arb_state_t` (IDLE, BUSY_IF, BUSY_DM, RESP).
  - Owner encoding `OWN_IF` = 0, `OWN_DM` = 1.
  - Default TIMEOUT constant.
- **One sub-module**: `mem_arb_pick`, the combinational grant selector. Inputs are `if_req`, `if_flush`, `dm_req` and the RR pointer; outputs are grant-valid and owner.

## Test plan
- **Single fetch**: `if_req`=1, `if_addr`=0x0040, memory returns 0x1234 after 2 BUSY cycles → `mem_addr`=0x0040, `mem_wr`=0; `if_done` pulses in cycle 4 with `if_rdata`=0x1234; `err`=0.
- **Simultaneous requests, macro undefined**: `if_req`=`dm_req`=1 → data granted first and `if_stall`=1 throughout; fetch granted in the IDLE cycle after `dm_done`. With `MEM_ARB_RR_EN` defined, consecutive conflicts alternate DM, IF, DM.
- **Data write**: `dm_wr`=1, addr 0x0100, wdata 0xBEEF → `mem_wr`=1, `mem_wdata`=0xBEEF held stable until `mem_done`; `dm_rdata` unchanged; `dm_done` pulses once.
- **Flush mid-fetch**: `if_flush` asserted in the 2nd BUSY_IF cycle → `mem_en` stays high until `mem_done`; `if_done` never asserts; `if_rdata` keeps its old value; next IDLE grants the new fetch.
- **Timeout**: memory never asserts `mem_done`, TIMEOUT=15 → `mem_en` high for exactly 15 cycles; then `dm_done`=`err`=1 for one cycle with `dm_rdata`=0x0000.
- **Reset mid-BUSY**: `rst`=0 asynchronously → `mem_en`, `done`, `err` and stalls are 0 immediately; after release, state is IDLE and a held request is granted again.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter (mem_arb).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } mem_arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector for mem_arb.
// MEM_ARB_RR_EN: on a conflict, grant the port not granted last instead of data-first.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic rr_ptr,
`endif
    input  logic if_req,
    input  logic if_flush,
    input  logic dm_req,
    output logic grant_vld,
    output logic grant_own
);

    logic if_ok;

    always_comb begin
        if_ok     = if_req & ~if_flush;
        grant_vld = if_ok | dm_req;
`ifdef MEM_ARB_RR_EN
        // rr_ptr holds the owner of the most recent grant
        if (if_ok && dm_req) begin
            grant_own = (rr_ptr == OWN_IF) ? OWN_DM : OWN_IF;
        end else begin
            grant_own = dm_req ? OWN_DM : OWN_IF;
        end
`else
        grant_own = dm_req ? OWN_DM : OWN_IF;
`endif
    end

endmodule

// File: rtl/mem_arb.sv
// Two-port (fetch/data) arbiter and sequencer for a single unified memory.
// MEM_ARB_RR_EN selects round-robin conflict resolution; default is data-over-fetch priority.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_wr,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_done,
    output logic                dm_stall,
    output logic                mem_en,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_done,
    output logic                err,
    output mem_arb_state_t      dbg_state
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    mem_arb_state_t    state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              own_q, wr_q, err_q, flush_pend;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, if_rdata_q, dm_rdata_q;
    logic              grant_vld, grant_own, busy, timeout_hit;

`ifdef MEM_ARB_RR_EN
    logic rr_ptr;
`endif

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .rr_ptr    (rr_ptr),
`endif
        .if_req    (if_req),
        .if_flush  (if_flush),
        .dm_req    (dm_req),
        .grant_vld (grant_vld),
        .grant_own (grant_own)
    );

    always_comb begin
        state_nxt   = state;
        busy        = (state == BUSY_IF) || (state == BUSY_DM);
        // mem_done in the final allowed cycle still counts as a normal completion
        timeout_hit = busy && !mem_done && (cnt == CNT_LAST);
        case (state)
            IDLE: begin
                if (grant_vld) state_nxt = (grant_own == OWN_DM) ? BUSY_DM : BUSY_IF;
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_done || timeout_hit) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            own_q      <= OWN_IF;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            flush_pend <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    cnt        <= '0;
                    err_q      <= 1'b0;
                    flush_pend <= 1'b0;
                    if (grant_vld) begin
                        own_q <= grant_own;
                        if (grant_own == OWN_DM) begin
                            wr_q    <= dm_wr;
                            addr_q  <= dm_addr;
                            wdata_q <= dm_wdata;
                        end else begin
                            wr_q    <= 1'b0;
                            addr_q  <= if_addr;
                            wdata_q <= '0;
                        end
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                    if (state == BUSY_IF && if_flush) flush_pend <= 1'b1;
                    if (mem_done || timeout_hit) begin
                        err_q <= !mem_done;
                        // a redirected fetch must leave the previous instruction visible
                        if (state == BUSY_IF) begin
                            if (!flush_pend && !if_flush) if_rdata_q <= mem_done ? mem_rdata : '0;
                        end else if (!wr_q) begin
                            dm_rdata_q <= mem_done ? mem_rdata : '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= OWN_IF;
        end else if (state == IDLE && grant_vld) begin
            rr_ptr <= grant_own;
        end
    end
`endif

    assign if_done   = (state == RESP) && (own_q == OWN_IF) && !flush_pend && !if_flush;
    assign dm_done   = (state == RESP) && (own_q == OWN_DM);
    assign err       = err_q && (if_done || dm_done);
    // stalls are forced low while reset is held
    assign if_stall  = rst & if_req & ~if_done;
    assign dm_stall  = rst & dm_req & ~dm_done;
    assign mem_en    = busy;
    assign mem_wr    = busy & wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: transaction-level model plus a reactive memory driven from the bench.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_wr = 1'b0, mem_done = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr, err;
  mem_arb_state_t dbg_state;

  mem_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // scoreboard and model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_if_rdata = '0;
  logic [DW-1:0] m_dm_rdata = '0;
  logic          m_last = OWN_IF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic pick(input logic ifr, input logic dmr);
`ifdef MEM_ARB_RR_EN
    if (ifr && dmr) return (m_last == OWN_IF) ? OWN_DM : OWN_IF;
`endif
    return dmr ? OWN_DM : OWN_IF;
  endfunction

  function automatic int rand_lat();
    if ($urandom_range(0, 7) == 0) return TO + 1 + $urandom_range(0, 3);
    return $urandom_range(1, 5);
  endfunction

  // Called at the negedge of an IDLE cycle; returns at the negedge of the response cycle.
  // lat > TO means the memory never answers; flush_k = cycle (1 = first busy) to pulse if_flush.
  task automatic access(input logic own, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rd, input int lat,
                        input int flush_k, output logic flushed_o);
    int done_k;
    logic to, busy_fl, show;
    logic [DW-1:0] old_rd, new_rd, o_rd;
    logic o_done, o_stall, x_done, x_stall, x_req;
    to      = (lat > TO);
    done_k  = to ? TO + 1 : lat + 1;
    busy_fl = (own == OWN_IF) && flush_k >= 1 && flush_k < done_k;
    show    = !((own == OWN_IF) && flush_k >= 1 && flush_k <= done_k);
    old_rd  = (own == OWN_DM) ? m_dm_rdata : m_if_rdata;
    if ((own == OWN_DM && wr) || busy_fl) new_rd = old_rd;
    else if (to) new_rd = '0;
    else new_rd = rd;
    if (show) exp_q.push_back(new_rd);
    m_last = own;
    if_flush = 1'b0;
    if (own == OWN_DM) begin
      dm_req = 1'b1; dm_wr = wr; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    mem_done  = 1'($urandom_range(0, 1));
    mem_rdata = DW'($urandom);
    #1;
    check("req_stall", (own == OWN_DM) ? dm_stall : if_stall, 1);
    check("grant_en", mem_en, 0);
    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk);
      if_flush  = (k == flush_k);
      mem_done  = (k == lat) || (k == done_k && $urandom_range(0, 1) == 1);
      mem_rdata = (k == lat) ? rd : DW'($urandom);
      #1;
      o_done  = (own == OWN_DM) ? dm_done  : if_done;
      o_stall = (own == OWN_DM) ? dm_stall : if_stall;
      o_rd    = (own == OWN_DM) ? dm_rdata : if_rdata;
      x_done  = (own == OWN_DM) ? if_done  : dm_done;
      x_stall = (own == OWN_DM) ? if_stall : dm_stall;
      x_req   = (own == OWN_DM) ? if_req   : dm_req;
      check("mem_en", mem_en, k < done_k);
      if (k < done_k) begin
        check("mem_addr", mem_addr, addr);
        check("mem_wr", mem_wr, own == OWN_DM && wr);
        if (own == OWN_DM && wr) check("mem_wdata", mem_wdata, wdata);
      end
      check("done", o_done, k == done_k && show);
      check("err", err, k == done_k && show && to);
      check("rdata", o_rd, (k == done_k) ? new_rd : old_rd);
      check("stall", o_stall, !(k == done_k && show));
      check("other_done", x_done, 0);
      check("other_stall", x_stall, x_req);
      if (o_done && exp_q.size() > 0) check("sb_rdata", o_rd, exp_q.pop_front());
    end
    if (own == OWN_DM) m_dm_rdata = new_rd;
    else m_if_rdata = new_rd;
    flushed_o = !show;
    if (show) begin
      if (own == OWN_DM) dm_req = 1'b0;
      else if_req = 1'b0;
    end
  endtask

  // Both ports request in the same IDLE cycle; the model decides who goes first.
  task automatic conflict();
    logic w, wr, fl;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] wd;
    ia = AW'($urandom); da = AW'($urandom); wd = DW'($urandom);
    wr = 1'($urandom_range(0, 1));
    if_req = 1'b1; if_addr = ia;
    dm_req = 1'b1; dm_wr = wr; dm_addr = da; dm_wdata = wd;
    w = pick(1'b1, 1'b1);
    if (w == OWN_DM) begin
      access(OWN_DM, wr, da, wd, DW'($urandom), rand_lat(), 0, fl);
      @(negedge clk);
      access(OWN_IF, 1'b0, ia, '0, DW'($urandom), rand_lat(), 0, fl);
    end else begin
      access(OWN_IF, 1'b0, ia, '0, DW'($urandom), rand_lat(), 0, fl);
      @(negedge clk);
      access(OWN_DM, wr, da, wd, DW'($urandom), rand_lat(), 0, fl);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      mem_done  = 1'($urandom_range(0, 1));
      mem_rdata = DW'($urandom);
      @(negedge clk);
      #1;
      check("idle_en", mem_en, 0);
      check("idle_if_done", if_done, 0);
      check("idle_dm_done", dm_done, 0);
      check("idle_err", err, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic fl;
    // reset state, with requests and a stray strobe present
    if_req = 1'b1; dm_req = 1'b1; mem_done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", dbg_state, IDLE);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_done", if_done, 0);
    check("rst_dm_done", dm_done, 0);
    check("rst_err", err, 0);
    check("rst_if_stall", if_stall, 0);
    check("rst_dm_stall", dm_stall, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    if_req = 1'b0; dm_req = 1'b0; mem_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // directed cases
    access(OWN_IF, 1'b0, 16'h0040, '0, 16'h1234, 2, 0, fl);      @(negedge clk);
    access(OWN_DM, 1'b1, 16'h0100, 16'hBEEF, 16'h5555, 3, 0, fl); @(negedge clk);
    access(OWN_DM, 1'b0, 16'h0102, '0, 16'hA5A5, 1, 0, fl);      @(negedge clk);
    conflict();                                                  @(negedge clk);
    access(OWN_DM, 1'b0, 16'h0104, '0, 16'h0F0F, 2, 0, fl);      @(negedge clk);
    conflict();                                                  @(negedge clk);
    conflict();                                                  @(negedge clk);
    access(OWN_IF, 1'b0, 16'h0200, '0, 16'h7777, 4, 2, fl);      @(negedge clk);
    access(OWN_IF, 1'b0, 16'h0300, '0, 16'h8888, 2, 0, fl);      @(negedge clk);
    access(OWN_IF, 1'b0, 16'h0400, '0, 16'h9999, 2, 3, fl);      @(negedge clk);
    access(OWN_IF, 1'b0, 16'h0500, '0, 16'h4321, 1, 0, fl);      @(negedge clk);
    access(OWN_DM, 1'b0, 16'h0600, '0, 16'h1111, 99, 0, fl);     @(negedge clk);
    access(OWN_DM, 1'b0, 16'h0602, '0, 16'h2222, TO, 0, fl);     @(negedge clk);
    access(OWN_IF, 1'b0, 16'h0700, '0, 16'h3333, 99, 0, fl);     @(negedge clk);
    idle_cycles(3);

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          access(OWN_IF, 1'b0, AW'($urandom), '0, DW'($urandom), rand_lat(),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, fl);
          if (fl) begin
            @(negedge clk);
            access(OWN_IF, 1'b0, AW'($urandom), '0, DW'($urandom), rand_lat(), 0, fl);
          end
        end
        1, 2: access(OWN_DM, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                     DW'($urandom), rand_lat(), 0, fl);
        default: conflict();
      endcase
      @(negedge clk);
      idle_cycles($urandom_range(0, 2));
    end

    // reset in the middle of a fetch
    if_req = 1'b1; if_addr = 16'h0ABC; if_flush = 1'b0; mem_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_rst_en", mem_en, 1);
    rst = 1'b0;
    #1;
    check("arst_mem_en", mem_en, 0);
    check("arst_if_done", if_done, 0);
    check("arst_dm_done", dm_done, 0);
    check("arst_err", err, 0);
    check("arst_if_stall", if_stall, 0);
    check("arst_dm_stall", dm_stall, 0);
    check("arst_state", dbg_state, IDLE);
    check("arst_if_rdata", if_rdata, 0);
    @(negedge clk);
    #1;
    check("arst_hold_en", mem_en, 0);
    check("arst_hold_done", if_done, 0);
    rst = 1'b1;
    m_if_rdata = '0; m_dm_rdata = '0; m_last = OWN_IF;
    access(OWN_IF, 1'b0, 16'h0ABC, '0, 16'h6B6B, 3, 0, fl);
    @(negedge clk);
    conflict();
    @(negedge clk);

    check("sb_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
